uart_transmitter: RTL and testbench

- Serialises bytes onto a UART line: 8N1 format (1 start, 8 data LSB-first, 1 stop), 115200 baud from a 50 MHz clock.
- It is the transmit-side counterpart of the team's UART receiver. It sends game state and score bytes back to the host PC.
- A small input FIFO absorbs bursts from game logic, and a valid/ready handshake accepts bytes.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_transmitter.sv | 158 +++++++++++++++
 tb/tb_uart_transmitter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART state encodings, line-rate and frame consts |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned CLK_FREQ_HZ     = 50_000_000;
   localparam int unsigned BAUD_RATE_DEF   = 115_200;
   localparam int unsigned CLK_PER_BIT_DEF = CLK_FREQ_HZ / BAUD_RATE_DEF;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   // Clock cycles occupied by one complete 8N1 frame on the line.
   function automatic int unsigned frame_cycles(input int unsigned clk_per_bit);
      return clk_per_bit * (1 + DATA_BITS + STOP_BITS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo : small show-ahead byte FIFO feeding the transmitter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_tx_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WIDTH      = 8
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          wr_en_in,
   input  logic [WIDTH-1:0]              wr_data_in,
   input  logic                          rd_en_in,
   output logic [WIDTH-1:0]              rd_data_op,
   output logic [$clog2(FIFO_DEPTH):0]   count_op,
   output logic                          full_op,
   output logic                          empty_op
);

   localparam int unsigned c_AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned c_CNTW = c_AW + 1;
   localparam logic [c_AW:0] c_FULL = c_CNTW'(FIFO_DEPTH);

   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign full_op    = (r_count == c_FULL);
   assign empty_op   = (r_count == '0);
   assign count_op   = r_count;
   assign rd_data_op = r_mem[r_rd_ptr];

   assign w_push = wr_en_in && !full_op;
   assign w_pop  = rd_en_in && !empty_op;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data_in;
   end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_transmitter : FIFO-buffered 8N1 UART serialiser, LSB first    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_RATE   = BAUD_RATE_DEF,
   parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       data_valid_in,
   input  logic [7:0] data_byte_in,
   output logic       ready_op,
   output logic       serial_data_op,
   output logic       busy_op,
   output logic       done_op
);

   localparam int unsigned c_CW   = $clog2(CLK_PER_BIT);
   localparam int unsigned c_AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned c_CNTW = c_AW + 1;
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLK_PER_BIT - 1);
   localparam logic [c_CW-1:0] c_CNT_DONE = c_CW'(CLK_PER_BIT - 2);
   localparam logic [2:0]      c_IDX_LAST = 3'(DATA_BITS - 1);
   localparam logic [c_AW:0]   c_DEPTH    = c_CNTW'(FIFO_DEPTH);

   if (CLK_PER_BIT < 2 || BAUD_RATE == 0 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_transmitter: illegal parameter set");
   end

   uart_state_e     r_state, w_state_next;
   logic [c_CW-1:0] r_cnt, w_cnt_next;
   logic [2:0]      r_idx, w_idx_next, w_idx_inc;
   logic [7:0]      r_shift, w_shift_next;
   logic            r_serial, w_serial_next;
   logic            r_done, w_done_next;
   logic            w_pop, w_push;
   logic [7:0]      w_fifo_data;
   logic [c_AW:0]   w_fifo_count;
   logic            w_fifo_full, w_fifo_empty;

   assign ready_op       = (w_fifo_count < c_DEPTH);
   assign w_push         = data_valid_in && !w_fifo_full;
   assign serial_data_op = r_serial;
   assign done_op        = r_done;
   assign busy_op        = (r_state != IDLE);
   assign w_idx_inc      = r_idx + 3'd1;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (8)
   ) u_fifo (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .wr_en_in   (w_push),
      .wr_data_in (data_byte_in),
      .rd_en_in   (w_pop),
      .rd_data_op (w_fifo_data),
      .count_op   (w_fifo_count),
      .full_op    (w_fifo_full),
      .empty_op   (w_fifo_empty)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_serial <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_idx    <= w_idx_next;
         r_shift  <= w_shift_next;
         r_serial <= w_serial_next;
         r_done   <= w_done_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt + 1'b1;
      w_idx_next    = r_idx;
      w_shift_next  = r_shift;
      w_serial_next = r_serial;
      w_done_next   = 1'b0;
      w_pop         = 1'b0;

      case (r_state)
         IDLE: begin
            w_serial_next = 1'b1;
            w_cnt_next    = '0;
            w_idx_next    = '0;
            if (!w_fifo_empty) begin
               w_pop         = 1'b1;
               w_shift_next  = w_fifo_data;
               w_serial_next = 1'b0;
               w_state_next  = START;
            end
         end

         START: begin
            if (r_cnt == c_CNT_LAST) begin
               w_cnt_next    = '0;
               w_idx_next    = '0;
               w_serial_next = r_shift[0];
               w_state_next  = DATA;
            end
         end

         DATA: begin
            if (r_cnt == c_CNT_LAST) begin
               w_cnt_next = '0;
               if (r_idx == c_IDX_LAST) begin
                  w_serial_next = 1'b1;
                  w_state_next  = STOP;
               end else begin
                  w_idx_next    = w_idx_inc;
                  w_serial_next = r_shift[w_idx_inc];
               end
            end
         end

         STOP: begin
            // Registered pulse lands in the final cycle of the stop bit.
            if (r_cnt == c_CNT_DONE) w_done_next = 1'b1;
            if (r_cnt == c_CNT_LAST) begin
               w_cnt_next = '0;
               if (!w_fifo_empty) begin
                  w_pop         = 1'b1;
                  w_shift_next  = w_fifo_data;
                  w_serial_next = 1'b0;
                  w_state_next  = START;
               end else begin
                  w_serial_next = 1'b1;
                  w_state_next  = IDLE;
               end
            end
         end

         default: begin
            w_state_next  = IDLE;
            w_serial_next = 1'b1;
            w_cnt_next    = '0;
            w_idx_next    = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_uart_transmitter : vector table, directed corners, random model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_transmitter;

   localparam int CPB    = 8;
   localparam int DEPTH  = 4;
   localparam int FRAME  = 10 * CPB;
   localparam int LB_CPB = 434;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready, serial, busy, done;
   logic       lb_valid = 1'b0;
   logic [7:0] lb_data = 8'h00;
   logic       lb_ready, lb_serial, lb_busy, lb_done;

   always #5 clk = ~clk;

   uart_transmitter #(.BAUD_RATE(115200), .CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .data_valid_in(valid), .data_byte_in(data),
      .ready_op(ready), .serial_data_op(serial), .busy_op(busy), .done_op(done));

   uart_transmitter #(.BAUD_RATE(115200), .CLK_PER_BIT(LB_CPB), .FIFO_DEPTH(DEPTH)) lb (
      .clk_in(clk), .rst_n_in(rst_n), .data_valid_in(lb_valid), .data_byte_in(lb_data),
      .ready_op(lb_ready), .serial_data_op(lb_serial), .busy_op(lb_busy), .done_op(lb_done));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted byte gets a frame start time; the line,
   // busy, done and ready levels are derived from those times arithmetically.
   int         edge_n = 0;
   int         acc_q[$];
   int         start_q[$];
   logic [7:0] byte_q[$];
   int         last_end = 0;
   bit         mon_en = 1'b0;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic int m_count(input int t);
      int c;
      c = 0;
      foreach (acc_q[k])   if (acc_q[k] <= t)   c++;
      foreach (start_q[k]) if (start_q[k] <= t) c--;
      return c;
   endfunction

   function automatic logic [3:0] m_exp(input int t);
      logic s, b, d;
      logic [9:0] fr;
      s = 1'b1; b = 1'b0; d = 1'b0;
      foreach (start_q[k]) begin
         if (t >= start_q[k] && t < start_q[k] + FRAME) begin
            fr = {1'b1, byte_q[k], 1'b0};
            s  = fr[(t - start_q[k]) / CPB];
            b  = 1'b1;
            d  = ((t - start_q[k]) == FRAME - 1);
         end
      end
      return {s, b, d, (m_count(t) < DEPTH)};
   endfunction

   function automatic void model_accept(input int e, input logic [7:0] d);
      int s;
      s = (e + 1 > last_end) ? e + 1 : last_end;
      acc_q.push_back(e);
      start_q.push_back(s);
      byte_q.push_back(d);
      last_end = s + FRAME;
   endfunction

   function automatic void model_reset();
      acc_q.delete();
      start_q.delete();
      byte_q.delete();
      last_end = 0;
   endfunction

   always @(negedge clk) begin
      if (mon_en)
         check("line{ser,busy,done,rdy}", 32'({serial, busy, done, ready}), 32'(m_exp(edge_n)));
   end

   // Offer (or withhold) a byte for the interval starting at this falling edge.
   task automatic drive(input bit v, input logic [7:0] d);
      @(negedge clk);
      valid = v;
      data  = d;
      if (v && rst_n && (m_count(edge_n) < DEPTH)) model_accept(edge_n + 1, d);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      model_reset();
      repeat (3) drive(1'b0, 8'h00);
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic rx_frame(output logic [7:0] b, output bit ok);
      int w;
      w = 0; ok = 1'b1; b = 8'h00;
      while (lb_serial !== 1'b0 && w < 30000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 30000) begin
         ok = 1'b0;
         return;
      end
      repeat (LB_CPB / 2) @(negedge clk);
      if (lb_serial !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (LB_CPB) @(negedge clk);
         b[i] = lb_serial;
      end
      repeat (LB_CPB) @(negedge clk);
      if (lb_serial !== 1'b1) ok = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // symbol k of the frame is frame[k]
   } vec_t;

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[5];
      int         bc, dc, lowc, w, base, first_b, last_b;
      logic [9:0] fr;
      logic [7:0] rb;
      bit         ok;
      logic [7:0] lb_bytes[3];

      vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
      vecs[1] = '{8'h00, 10'b1_0000_0000_0};
      vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
      vecs[3] = '{8'h3C, 10'b1_0011_1100_0};
      vecs[4] = '{8'h81, 10'b1_1000_0001_0};

      // Reset state and quiet line
      do_reset();
      drive(1'b0, 8'h00);
      check("rst_serial", 32'(serial), 32'd1);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_done",   32'(done),   32'd0);
      check("rst_ready",  32'(ready),  32'd1);
      lowc = 0;
      repeat (100) begin
         drive(1'b0, 8'h00);
         if (serial !== 1'b1) lowc++;
      end
      check("idle_line_low_cycles", 32'(lowc), 32'd0);

      // Table of single frames with hand-written expected symbol sequences
      for (int v = 0; v < 5; v++) begin
         w = 0;
         while (busy && w < 200) begin
            drive(1'b0, 8'h00);
            w++;
         end
         drive(1'b1, vecs[v].data);
         drive(1'b0, 8'h00);
         check("pre_start_serial", 32'(serial), 32'd1);
         fr = vecs[v].frame;
         bc = 0; dc = 0;
         for (int k = 0; k < FRAME; k++) begin
            drive(1'b0, 8'h00);
            check("frame_symbol", 32'(serial), 32'(fr[k / CPB]));
            bc += int'(busy);
            dc += int'(done);
            if (k == FRAME - 1) check("done_last_cycle", 32'(done), 32'd1);
         end
         check("busy_cycles", 32'(bc), 32'(FRAME));
         check("done_pulses", 32'(dc), 32'd1);
         drive(1'b0, 8'h00);
         check("post_frame_busy", 32'(busy), 32'd0);
         check("post_frame_serial", 32'(serial), 32'd1);
      end

      // Burst of six: fifth fills the FIFO, sixth is refused
      do_reset();
      bc = 0; dc = 0; first_b = -1; last_b = -1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(i + 1));
         if (i == 5) check("burst_ready_6th", 32'(ready), 32'd0);
         if (busy) begin
            if (first_b < 0) first_b = edge_n;
            last_b = edge_n;
         end
         bc += int'(busy);
         dc += int'(done);
      end
      repeat (430) begin
         drive(1'b0, 8'h00);
         if (busy) begin
            if (first_b < 0) first_b = edge_n;
            last_b = edge_n;
         end
         bc += int'(busy);
         dc += int'(done);
      end
      check("burst_busy_cycles", 32'(bc), 32'(5 * FRAME));
      check("burst_no_gap", 32'(last_b - first_b + 1), 32'(5 * FRAME));
      check("burst_done_pulses", 32'(dc), 32'd5);

      // Push while full as a pop happens: refused, then accepted next cycle
      do_reset();
      drive(1'b1, 8'h10);
      base = edge_n;
      for (int i = 1; i < 5; i++) drive(1'b1, 8'(8'h10 + i));
      while (edge_n < base + 80) drive(1'b0, 8'h00);
      drive(1'b1, 8'h77);
      check("full_ready_at_pop", 32'(ready), 32'd0);
      drive(1'b1, 8'h77);
      check("ready_after_pop", 32'(ready), 32'd1);
      dc = 0;
      repeat (420) begin
         drive(1'b0, 8'h00);
         dc += int'(done);
      end
      check("full_pop_done_pulses", 32'(dc), 32'd5);

      // Reset asserted mid-DATA
      do_reset();
      drive(1'b1, 8'h3C);
      repeat (40) drive(1'b0, 8'h00);
      check("mid_frame_busy", 32'(busy), 32'd1);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      model_reset();
      #1;
      check("async_rst_serial", 32'(serial), 32'd1);
      check("async_rst_busy",   32'(busy),   32'd0);
      check("async_rst_ready",  32'(ready),  32'd1);
      repeat (3) drive(1'b0, 8'h00);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      dc = 0; lowc = 0;
      repeat (100) begin
         drive(1'b0, 8'h00);
         dc += int'(done);
         if (serial !== 1'b1) lowc++;
      end
      check("after_rst_done", 32'(dc), 32'd0);
      check("after_rst_low", 32'(lowc), 32'd0);

      // Randomised traffic against the model
      do_reset();
      for (int blk = 0; blk < 10; blk++) begin
         int thr;
         thr = int'($urandom_range(1, 8));
         repeat (250) drive(($urandom_range(0, 7) < thr), 8'($urandom));
      end
      repeat (5 * FRAME + 20) drive(1'b0, 8'h00);
      check("rand_end_busy", 32'(busy), 32'd0);
      check("rand_end_ready", 32'(ready), 32'd1);

      // Loopback at the real bit period into a behavioural receiver
      mon_en = 1'b0;
      lb_bytes[0] = 8'h00;
      lb_bytes[1] = 8'hFF;
      lb_bytes[2] = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lb_ready", 32'(lb_ready), 32'd1);
         lb_valid = 1'b1;
         lb_data  = lb_bytes[i];
      end
      @(negedge clk);
      lb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_frame(rb, ok);
         check("lb_frame_ok", 32'(ok), 32'd1);
         check("lb_byte", 32'(rb), 32'(lb_bytes[i]));
      end
      dc = 0; w = 0;
      while (lb_busy && w < 2000) begin
         @(negedge clk);
         dc += int'(lb_done);
         w++;
      end
      check("lb_idle_after", 32'(lb_busy), 32'd0);
      check("lb_last_done", 32'(dc), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
